// File: rtl/seg_pkg.sv
// Shared constants and entry type for the segment-to-ASCII decoder.
// Segment codes are active-low, with bits a..g ordered from MSB to LSB.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b1110010;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    typedef struct packed {
        logic [7:0] chr;
        logic       dp;
    } seg_entry_t;

    localparam int ENTRY_W = $bits(seg_entry_t);

endpackage

// File: rtl/seg_to_ascii_if.sv
// Handshake bundle for seg_to_ascii: a pattern input port and a character output port.
// The master side is the producer/consumer environment; the slave side is the decoder.
interface seg_to_ascii_if;
    import seg_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_seg;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_dp;

    modport master (
        output in_valid, in_seg, out_ready,
        input  in_ready, out_valid, out_char, out_dp
    );

    modport slave (
        input  in_valid, in_seg, out_ready,
        output in_ready, out_valid, out_char, out_dp
    );

endinterface

// File: rtl/seg_fifo.sv
// Generic show-ahead synchronous FIFO. The head entry is visible on rdata whenever the FIFO is not empty.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module seg_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is left unreset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/seg_to_ascii.sv
// Decodes active-low 7-segment patterns to ASCII and queues them in a show-ahead FIFO.
// Define SEG_DROP_INVALID_EN to discard unrecognised patterns instead of queueing them as '?'.
module seg_to_ascii
    import seg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    seg_to_ascii_if.slave    bus,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    logic       dec_ok;
    logic [7:0] dec_char;
    logic       accept;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    seg_entry_t entry_in;
    seg_entry_t head;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // The decimal point does not take part in matching.
    always_comb begin
        dec_ok   = 1'b1;
        dec_char = ASCII_QMARK;
        case (bus.in_seg[7:1])
            SEG_0:     dec_char = 8'h30;
            SEG_1:     dec_char = 8'h31;
            SEG_2:     dec_char = 8'h32;
            SEG_3:     dec_char = 8'h33;
            SEG_4:     dec_char = 8'h34;
            SEG_5:     dec_char = 8'h35;
            SEG_6:     dec_char = 8'h36;
            SEG_7:     dec_char = 8'h37;
            SEG_8:     dec_char = 8'h38;
            SEG_9:     dec_char = 8'h39;
            SEG_A:     dec_char = 8'h41;
            SEG_B:     dec_char = 8'h42;
            SEG_C:     dec_char = 8'h43;
            SEG_D:     dec_char = 8'h44;
            SEG_E:     dec_char = 8'h45;
            SEG_F:     dec_char = 8'h46;
            SEG_BLANK: dec_char = ASCII_SPACE;
            default: begin
                dec_ok   = 1'b0;
                dec_char = ASCII_QMARK;
            end
        endcase
    end

    assign accept       = bus.in_valid && bus.in_ready;
    assign entry_in.chr = dec_char;
    assign entry_in.dp  = !bus.in_seg[0];

`ifdef SEG_DROP_INVALID_EN
    assign push = accept && dec_ok;
`else
    assign push = accept;
`endif

    assign pop = !empty && bus.out_ready;

    seg_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (entry_in),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // A pop never frees a slot for a push in the same cycle.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_char  = empty ? 8'h00 : head.chr;
    assign bus.out_dp    = !empty && head.dp;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= accept && !dec_ok;
            if (accept && !dec_ok) err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_seg_to_ascii.sv
// Directed bench for seg_to_ascii: a queue-based reference model is checked every cycle,
// and literal expectations from the decode table pin that model.
module tb_seg_to_ascii;

    localparam int DEPTH = 4;
`ifdef SEG_DROP_INVALID_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       err_pulse;
    logic [7:0] err_cnt;

    seg_to_ascii_if bus();

    seg_to_ascii #(.DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Digit/hex shapes, index i is the glyph for hex value i.
    logic [6:0] pats [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sg(input logic [6:0] p, input bit dp);
        return {p, ~dp};
    endfunction

    // Returns {char, dp}; bad is set for a pattern outside the table.
    function automatic logic [8:0] model_decode(input logic [7:0] seg, output bit bad);
        logic [7:0] c;
        bad = 1'b1;
        c   = 8'h3F;
        if (seg[7:1] == 7'h7F) begin
            c = 8'h20; bad = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            if (pats[i] == seg[7:1]) begin
                c   = (i < 10) ? 8'(48 + i) : 8'(65 + i - 10);
                bad = 1'b0;
            end
        end
        return {c, ~seg[0]};
    endfunction

    logic [8:0] mq [$];
    logic [7:0] cap [$];
    int         m_cnt   = 0;
    bit         m_pulse = 1'b0;
    bit         live    = 1'b0;
    bit         p_rst   = 1'b0;
    bit         p_acc   = 1'b0;
    bit         p_pop   = 1'b0;
    logic [7:0] p_seg;

    always @(negedge clk) begin
        if (live) begin
            check("in_ready",  bus.in_ready,  mq.size() < DEPTH);
            check("out_valid", bus.out_valid, mq.size() > 0);
            check("out_char",  bus.out_char,  (mq.size() > 0) ? mq[0][8:1] : 8'h00);
            check("out_dp",    bus.out_dp,    (mq.size() > 0) ? mq[0][0] : 1'b0);
            check("err_pulse", err_pulse,     m_pulse);
            check("err_cnt",   err_cnt,       m_cnt);
            if (!rst && bus.out_valid && bus.out_ready) cap.push_back(bus.out_char);
        end
        p_rst = rst;
        p_seg = bus.in_seg;
        p_acc = !rst && bus.in_valid && (mq.size() < DEPTH);
        p_pop = !rst && bus.out_ready && (mq.size() > 0);
    end

    always @(posedge clk) begin
        logic [8:0] e;
        bit bad;
        if (p_rst) begin
            mq.delete();
            m_cnt   = 0;
            m_pulse = 1'b0;
            live    = 1'b1;
        end else if (live) begin
            e = model_decode(p_seg, bad);
            m_pulse = p_acc && bad;
            if (p_acc && bad && m_cnt < 255) m_cnt++;
            if (p_pop) void'(mq.pop_front());
            if (p_acc && !(DROP && bad)) mq.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_seg   = s;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_wait", n < 50, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("drain_wait", n < 20, 1'b1);
        bus.out_ready = 1'b0;
    endtask

    logic [7:0] sweep_exp [17] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                   8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h20};
    logic [7:0] bp_exp [4]     = '{8'h35, 8'h36, 8'h37, 8'h38};
    logic [7:0] sim_exp [5]    = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_seg    = 8'hFF;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_char",  bus.out_char,  8'h00);
        check("rst_err_cnt",   err_cnt,       8'h00);

        send(8'b00000011);
        check("first_valid", bus.out_valid, 1'b1);
        check("first_char",  bus.out_char,  8'h30);
        check("first_dp",    bus.out_dp,    1'b0);
        drain();

        // All sixteen glyphs plus blank, streamed with the consumer always ready.
        cap.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(sg(pats[i], 1'b0));
        send(8'hFF);
        tick();
        tick();
        bus.out_ready = 1'b0;
        check("sweep_count", cap.size(), 17);
        for (int i = 0; i < 17; i++)
            if (i < cap.size()) check("sweep_char", cap[i], sweep_exp[i]);
        check("sweep_err_cnt", err_cnt, 8'h00);

        send(8'b10011110);
        check("dp_char", bus.out_char, 8'h31);
        check("dp_bit",  bus.out_dp,   1'b1);
        drain();

        // Six offers against a stalled consumer: only four fit.
        cap.delete();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_seg   = sg(pats[5 + i], 1'b0);
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", acc, 4);
        check("bp_in_ready", bus.in_ready, 1'b0);
        tick();
        tick();
        tick();
        check("bp_head_hold", bus.out_char, 8'h35);
        drain();
        check("bp_count", cap.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < cap.size()) check("bp_order", cap[i], bp_exp[i]);

        // Push and pop together while two entries are buffered.
        cap.delete();
        send(sg(pats[11], 1'b0));
        send(sg(pats[12], 1'b0));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_seg = sg(pats[13 + i], 1'b0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("sim_valid", bus.out_valid, 1'b1);
        check("sim_head",  bus.out_char,  8'h45);
        drain();
        check("sim_count", cap.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < cap.size()) check("sim_order", cap[i], sim_exp[i]);

        send(8'b01010101);
        check("bad_pulse", err_pulse, 1'b1);
        check("bad_cnt",   err_cnt,   8'h01);
        if (DROP) begin
            check("bad_dropped", bus.out_valid, 1'b0);
        end else begin
            check("bad_valid", bus.out_valid, 1'b1);
            check("bad_char",  bus.out_char,  8'h3F);
            check("bad_dp",    bus.out_dp,    1'b0);
        end
        tick();
        check("bad_pulse_end", err_pulse, 1'b0);
        check("bad_cnt_hold",  err_cnt,   8'h01);
        drain();

        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) send(8'b01010101);
        tick();
        bus.out_ready = 1'b0;
        check("sat_cnt", err_cnt, 8'hFF);
        drain();

        // Reset with entries buffered and a handshake offered in the reset cycle.
        send(sg(pats[1], 1'b0));
        send(sg(pats[2], 1'b0));
        send(sg(pats[3], 1'b0));
        check("pre_rst_valid", bus.out_valid, 1'b1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_seg   = sg(pats[4], 1'b0);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_rst_valid",    bus.out_valid, 1'b0);
        check("mid_rst_err_cnt",  err_cnt,       8'h00);
        check("mid_rst_in_ready", bus.in_ready,  1'b1);
        tick();
        check("mid_rst_no_push",  bus.out_valid, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_to_ascii.md
Name: seg_to_ascii

Overview:
- Reverse path of the character-to-segment display decoder.
- Accepts active-low 7-segment patterns over a valid/ready handshake, decodes each into the ASCII character it represents ('0'-'9', 'A'-'F', space), and buffers the results in a small FIFO. The FIFO drains through a second valid/ready port.
- Used for display loop-back checking and for pattern-entry front ends such as switches or UART.
- Tracks unrecognised patterns with a pulse and a saturating counter.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_seg is presented.
- in_ready  output  1  block can accept in_seg this cycle.
- in_seg  input  8  segment pattern, active-low. Bit order a,b,c,d,e,f,g,dp from MSB to LSB.
- out_valid  output  1  out_char/out_dp are valid.
- out_ready  input  1  consumer takes the head entry.
- out_char  output  8  decoded ASCII code.
- out_dp  output  1  decimal point was lit (in_seg[0]==0).
- err_pulse  output  1  one-cycle pulse: an unrecognised pattern was accepted.
- err_cnt  output  ERR_W  saturating count of unrecognised patterns.

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous and active-high.
- Reset values:
  - FIFO is emptied.
  - out_valid=0, out_char=8'h00, out_dp=0.
  - err_pulse=0, err_cnt=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation: all buffered entries are discarded. A handshake in the same cycle as rst is ignored.
- Accept: a pattern is accepted on a rising edge where in_valid && in_ready. in_ready = !full. A pop in the same cycle does not free a slot; there is no full-bypass.
- Decode:
  - Combinational on in_seg[7:1]; dp is ignored for matching.
  - Recognised patterns map to ASCII 48..57 and 65..70: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, B=1100000, C=1110010, D=1000010, E=0110000, F=0111000.
  - All-off (1111111) maps to 8'h20 (space) and is not an error.
  - Any other pattern is unrecognised.
- Write: the decoded {char, dp} is written into the FIFO on the accepting edge.
- Latency: an entry accepted at edge N is visible on out_valid/out_char after edge N. This is 1 cycle of latency, including when the FIFO was empty (no empty-bypass).
- Output: show-ahead. out_char/out_dp hold the head entry whenever out_valid=1. The entry is popped on an edge with out_valid && out_ready. Outputs are stable while out_valid && !out_ready.
- Simultaneous push and pop (FIFO not full, not empty): both happen and occupancy is unchanged.
- Pointers: wrap modulo DEPTH. Full/empty are distinguished with an extra pointer bit.
- Errors:
  - When an accepted pattern is unrecognised, err_pulse is high for exactly the cycle after the accepting edge.
  - err_cnt increments on that same edge and saturates at all-ones; it never wraps.
  - An offered pattern that is not accepted (in_ready=0) never counts.

Optional Feature:
- Macro: SEG_DROP_INVALID_EN.
- Defined: unrecognised patterns are accepted (in_ready semantics unchanged) and counted, but not written to the FIFO.
- Undefined (default): unrecognised patterns are written as 8'h3F ('?') with their dp bit.

Decomposition:
- Package seg_pkg:
  - 7-bit segment constants SEG_0..SEG_F and SEG_BLANK.
  - ASCII constants ASCII_SPACE=8'h20 and ASCII_QMARK=8'h3F.
  - Entry typedef {char[7:0], dp}.
- Sub-module seg_fifo: a generic show-ahead synchronous FIFO, parameterised by width and DEPTH, with push/pop/full/empty.
- Decode logic and error logic stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles → in_ready=1, out_valid=0, err_cnt=0. Then send in_seg=8'b00000011 → one cycle later out_char=8'h30, out_dp=0.
- Full sweep: send all 16 recognised patterns plus 8'hFF with out_ready=1 → outputs in order are 0x30..0x39, 0x41..0x46, 0x20; err_cnt stays 0.
- Decimal point: in_seg=8'b10011110 → out_char=8'h31, out_dp=1.
- Backpressure: out_ready=0, offer 6 patterns → first 4 accepted, in_ready=0 afterwards, head held stable. Raise out_ready → entries drain in FIFO order. Repeat with push and pop in the same cycle → occupancy unchanged.
- Invalid pattern: in_seg=8'b01010101 → err_pulse high 1 cycle, err_cnt=1. out_char=8'h3F (macro undefined), or no entry produced (SEG_DROP_INVALID_EN).
- Saturation and reset: 300 invalid patterns → err_cnt=8'hFF. Assert rst with 3 entries buffered → next cycle out_valid=0, err_cnt=0.
